sap1_controller_sequencer: RTL and testbench

Controller-sequencer for the SAP-1 computer. It generates the control word that drives the program counter (`Cp`, `Ep`), MAR, RAM, instruction register, accumulator, B register, adder/subtractor and output register. A six-state one-hot ring counter steps the T-states on the falling clock edge, so every control line is stable before the rising edge at which the datapath registers sample it. The block decodes the opcode nibble from the instruction register and sits directly upstream of the program counter.

---
 rtl/sap1_pkg.sv | 80 ++++++++
 rtl/sap1_ring_counter.sv | 56 +++++
 rtl/sap1_controller_sequencer.sv | 159 +++++++++++++++
 tb/tb_sap1_controller_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// sap1_pkg -- shared definitions for the SAP-1 controller-sequencer.
//
// Contents:
//   OP_*        opcode nibble values decoded from the instruction register
//   T*_ONEHOT   one-hot T-state encodings (bit0 = T1); HALT is all-zero
//   t_state_e   ring-counter state type built from those encodings
//   CON_*       bit positions of each control line inside con_word_t
//   con_word_t  packed control word; field order matches the CON_* indices
//   CON_IDLE    control word with every line at its inactive level
//
// Optional feature macro used by the files that import this package:
//   SAP1_EARLY_FETCH_EN  (see sap1_controller_sequencer.sv)

package sap1_pkg;

   // Opcode nibble values; every other value is a NOP.
   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // One-hot T-state encodings.
   localparam logic [5:0] T1_ONEHOT   = 6'b000001;
   localparam logic [5:0] T2_ONEHOT   = 6'b000010;
   localparam logic [5:0] T3_ONEHOT   = 6'b000100;
   localparam logic [5:0] T4_ONEHOT   = 6'b001000;
   localparam logic [5:0] T5_ONEHOT   = 6'b010000;
   localparam logic [5:0] T6_ONEHOT   = 6'b100000;
   localparam logic [5:0] HALT_ONEHOT = 6'b000000;

   typedef enum logic [5:0] {
      ST_T1   = T1_ONEHOT,
      ST_T2   = T2_ONEHOT,
      ST_T3   = T3_ONEHOT,
      ST_T4   = T4_ONEHOT,
      ST_T5   = T5_ONEHOT,
      ST_T6   = T6_ONEHOT,
      ST_HALT = HALT_ONEHOT
   } t_state_e;

   // Control-word bit positions (MSB first, same order as con_word_t).
   localparam int CON_WIDTH  = 12;
   localparam int CON_CP     = 11;
   localparam int CON_EP     = 10;
   localparam int CON_LM_BAR = 9;
   localparam int CON_CE_BAR = 8;
   localparam int CON_LI_BAR = 7;
   localparam int CON_EI_BAR = 6;
   localparam int CON_LA_BAR = 5;
   localparam int CON_EA     = 4;
   localparam int CON_SU     = 3;
   localparam int CON_EU     = 2;
   localparam int CON_LB_BAR = 1;
   localparam int CON_LO_BAR = 0;

   typedef struct packed {
      logic cp;
      logic ep;
      logic lm_bar;
      logic ce_bar;
      logic li_bar;
      logic ei_bar;
      logic la_bar;
      logic ea;
      logic su;
      logic eu;
      logic lb_bar;
      logic lo_bar;
   } con_word_t;

   // Active-low lines idle at 1, active-high lines idle at 0.
   localparam logic [CON_WIDTH-1:0] CON_ACTIVE_LOW_MASK = CON_WIDTH'(
      (1 << CON_LM_BAR) | (1 << CON_CE_BAR) | (1 << CON_LI_BAR) |
      (1 << CON_EI_BAR) | (1 << CON_LA_BAR) | (1 << CON_LB_BAR) |
      (1 << CON_LO_BAR));

   localparam con_word_t CON_IDLE = con_word_t'(CON_ACTIVE_LOW_MASK);

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter -- six-state one-hot T-state ring counter.
//
// Steps T1->T2->...->T6->T1 on the falling clock edge so the control
// decode settles before the datapath samples on the rising edge.
//
// Ports:
//   clk        in   system clock (state advances on negedge)
//   clear_bar  in   asynchronous active-low clear, forces T1
//   restart    in   next state is T1 regardless of the current state
//   halt       in   next state is the all-zero HALT state (wins over restart)
//   state      out  current T-state (one-hot, bit0 = T1; all-zero = HALT)

module sap1_ring_counter
   import sap1_pkg::*;
(
   input  logic     clk,
   input  logic     clear_bar,
   input  logic     restart,
   input  logic     halt,
   output t_state_e state
);

   t_state_e state_q;
   t_state_e state_nx;

   always_ff @(negedge clk or negedge clear_bar) begin
      if (!clear_bar) begin
         state_q <= ST_T1;
      end else begin
         state_q <= state_nx;
      end
   end

   always_comb begin
      state_nx = state_q;
      if (halt) begin
         state_nx = ST_HALT;
      end else if (restart) begin
         state_nx = ST_T1;
      end else begin
         unique case (state_q)
            ST_T1:   state_nx = ST_T2;
            ST_T2:   state_nx = ST_T3;
            ST_T3:   state_nx = ST_T4;
            ST_T4:   state_nx = ST_T5;
            ST_T5:   state_nx = ST_T6;
            ST_T6:   state_nx = ST_T1;
            ST_HALT: state_nx = ST_HALT;  // only clear_bar leaves HALT
            default: state_nx = ST_T1;    // recover from a corrupted ring
         endcase
      end
   end

   assign state = state_q;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// sap1_controller_sequencer -- SAP-1 control unit.
//
// Decodes the current T-state and the instruction-register opcode nibble
// into the SAP-1 control word. T1..T3 fetch (opcode ignored); T4..T6
// execute LDA/ADD/SUB/OUT, any unlisted opcode is a NOP, and HLT sends the
// ring counter to the all-zero HALT state instead of T4. HALT is left only
// through clear_bar.
//
// Optional feature macro:
//   SAP1_EARLY_FETCH_EN  when defined, an instruction returns to T1 right
//                        after its last productive T-state (LDA 5 cycles,
//                        OUT 4, NOP 3, ADD/SUB 6). When undefined every
//                        instruction takes 6 cycles.
//
// Ports:
//   clk        in   system clock, shared with the datapath
//   clear_bar  in   asynchronous active-low reset
//   opcode     in   [OPCODE_WIDTH] upper nibble of the IR, valid T4..T6
//   Cp, Ep     out  program counter increment / bus enable
//   Lm_bar     out  MAR load (active-low)
//   Ce_bar     out  RAM bus enable (active-low)
//   Li_bar     out  IR load (active-low)
//   Ei_bar     out  IR address-field bus enable (active-low)
//   La_bar, Ea out  accumulator load (active-low) / bus enable
//   Su, Eu     out  subtract select / adder-subtractor bus enable
//   Lb_bar     out  B register load (active-low)
//   Lo_bar     out  output register load (active-low)
//   hlt        out  halt indicator
//   t_state    out  [6] one-hot current T-state, bit0 = T1 (0 in HALT)

module sap1_controller_sequencer
   import sap1_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    clear_bar,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   output logic                    Cp,
   output logic                    Ep,
   output logic                    Lm_bar,
   output logic                    Ce_bar,
   output logic                    Li_bar,
   output logic                    Ei_bar,
   output logic                    La_bar,
   output logic                    Ea,
   output logic                    Su,
   output logic                    Eu,
   output logic                    Lb_bar,
   output logic                    Lo_bar,
   output logic                    hlt,
   output logic [5:0]              t_state
);

   t_state_e  state;
   con_word_t cw;
   con_word_t cw_out;
   logic      is_lda;
   logic      is_add;
   logic      is_sub;
   logic      is_out;
   logic      is_hlt;
   logic      halt_req;
   logic      restart_req;

   sap1_ring_counter u_ring (
      .clk       (clk),
      .clear_bar (clear_bar),
      .restart   (restart_req),
      .halt      (halt_req),
      .state     (state)
   );

   assign is_lda = (opcode == OPCODE_WIDTH'(OP_LDA));
   assign is_add = (opcode == OPCODE_WIDTH'(OP_ADD));
   assign is_sub = (opcode == OPCODE_WIDTH'(OP_SUB));
   assign is_out = (opcode == OPCODE_WIDTH'(OP_OUT));
   assign is_hlt = (opcode == OPCODE_WIDTH'(OP_HLT));

   // The IR has been loaded by the rising edge inside T3, so the falling
   // edge that ends T3 already sees the new opcode: HLT diverts there and
   // T4 is never entered.
   assign halt_req = (state == ST_T3) && is_hlt;

`ifdef SAP1_EARLY_FETCH_EN
   logic is_nop;
   assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
   assign restart_req = ((state == ST_T3) && is_nop) ||
                        ((state == ST_T4) && is_out) ||
                        ((state == ST_T5) && is_lda);
`else
   assign restart_req = 1'b0;
`endif

   // Control-word decode: start idle, then raise what the state needs.
   always_comb begin
      cw = CON_IDLE;
      unique case (state)
         ST_T1: begin
            cw.ep     = 1'b1;
            cw.lm_bar = 1'b0;
         end
         ST_T2: begin
            cw.cp = 1'b1;
         end
         ST_T3: begin
            cw.ce_bar = 1'b0;
            cw.li_bar = 1'b0;
         end
         ST_T4: begin
            if (is_lda || is_add || is_sub) begin
               cw.ei_bar = 1'b0;
               cw.lm_bar = 1'b0;
            end else if (is_out) begin
               cw.ea     = 1'b1;
               cw.lo_bar = 1'b0;
            end
         end
         ST_T5: begin
            if (is_lda) begin
               cw.ce_bar = 1'b0;
               cw.la_bar = 1'b0;
            end else if (is_add || is_sub) begin
               cw.ce_bar = 1'b0;
               cw.lb_bar = 1'b0;
            end
         end
         ST_T6: begin
            if (is_add || is_sub) begin
               cw.eu     = 1'b1;
               cw.la_bar = 1'b0;
               cw.su     = is_sub;
            end
         end
         default: begin
            cw = CON_IDLE;  // HALT or illegal encoding
         end
      endcase
   end

   // While clear_bar is low the ring sits in T1, but nothing may fire.
   assign cw_out = clear_bar ? cw : CON_IDLE;

   assign Cp      = cw_out.cp;
   assign Ep      = cw_out.ep;
   assign Lm_bar  = cw_out.lm_bar;
   assign Ce_bar  = cw_out.ce_bar;
   assign Li_bar  = cw_out.li_bar;
   assign Ei_bar  = cw_out.ei_bar;
   assign La_bar  = cw_out.la_bar;
   assign Ea      = cw_out.ea;
   assign Su      = cw_out.su;
   assign Eu      = cw_out.eu;
   assign Lb_bar  = cw_out.lb_bar;
   assign Lo_bar  = cw_out.lo_bar;
   assign hlt     = clear_bar && (state == ST_HALT);
   assign t_state = state;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// tb_sap1_controller_sequencer -- self-checking bench for the SAP-1
// controller-sequencer. Runs a directed instruction list, then a random
// program, comparing every mid-state sample against an instruction-level
// reference model. Honours SAP1_EARLY_FETCH_EN for instruction lengths.

module tb_sap1_controller_sequencer;

   // ---------------- clock / reset ----------------
   logic       clk;
   logic       clear_bar;
   logic [3:0] opcode;
   logic       Cp, Ep, Lm_bar, Ce_bar, Li_bar, Ei_bar, La_bar;
   logic       Ea, Su, Eu, Lb_bar, Lo_bar, hlt;
   logic [5:0] t_state;

   int checks = 0;
   int passed = 0;

   // Observation vector: {t_state[6], hlt, Cp, Ep, Lm_bar, Ce_bar, Li_bar,
   //                      Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
   localparam int W = 19;
   logic [W-1:0] exp_q[$];

   sap1_controller_sequencer #(.OPCODE_WIDTH(4)) dut (
      .clk       (clk),
      .clear_bar (clear_bar),
      .opcode    (opcode),
      .Cp        (Cp),
      .Ep        (Ep),
      .Lm_bar    (Lm_bar),
      .Ce_bar    (Ce_bar),
      .Li_bar    (Li_bar),
      .Ei_bar    (Ei_bar),
      .La_bar    (La_bar),
      .Ea        (Ea),
      .Su        (Su),
      .Eu        (Eu),
      .Lb_bar    (Lb_bar),
      .Lo_bar    (Lo_bar),
      .hlt       (hlt),
      .t_state   (t_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   // Cycles from one T1 to the next for a given opcode (HLT: fetch only).
   function automatic int instr_len(input logic [3:0] op);
      if (op == 4'hF) return 3;
`ifdef SAP1_EARLY_FETCH_EN
      case (op)
         4'h0:       return 5;
         4'h1, 4'h2: return 6;
         4'hE:       return 4;
         default:    return 3;
      endcase
`else
      return 6;
`endif
   endfunction

   function automatic logic [W-1:0] pack_vec(
      input logic [5:0] ts, input logic h,
      input logic cp, input logic ep, input logic lm, input logic ce,
      input logic li, input logic ei, input logic la, input logic ea,
      input logic su, input logic eu, input logic lb, input logic lo);
      return {ts, h, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
   endfunction

   // Expected outputs at T-state (step+1) of instruction op.
   function automatic logic [W-1:0] exp_vec(input logic [3:0] op, input int step);
      logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
      logic [5:0] ts;
      cp = 0; ep = 0; lm = 1; ce = 1; li = 1; ei = 1;
      la = 1; ea = 0; su = 0; eu = 0; lb = 1; lo = 1;
      ts = 6'd1 << step;
      if (step == 0) begin ep = 1; lm = 0; end
      else if (step == 1) cp = 1;
      else if (step == 2) begin ce = 0; li = 0; end
      else if (op == 4'h0) begin
         if (step == 3) begin ei = 0; lm = 0; end
         if (step == 4) begin ce = 0; la = 0; end
      end else if (op == 4'h1 || op == 4'h2) begin
         if (step == 3) begin ei = 0; lm = 0; end
         if (step == 4) begin ce = 0; lb = 0; end
         if (step == 5) begin eu = 1; la = 0; su = (op == 4'h2); end
      end else if (op == 4'hE) begin
         if (step == 3) begin ea = 1; lo = 0; end
      end
      return pack_vec(ts, 1'b0, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo);
   endfunction

   function automatic logic [W-1:0] reset_vec();
      return pack_vec(6'b000001, 1'b0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
   endfunction

   function automatic logic [W-1:0] halt_vec();
      return pack_vec(6'b000000, 1'b1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1);
   endfunction

   function automatic logic [W-1:0] obs();
      return {t_state, hlt, Cp, Ep, Lm_bar, Ce_bar, Li_bar, Ei_bar,
              La_bar, Ea, Su, Eu, Lb_bar, Lo_bar};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   // Pulse clear_bar low across two falling edges, release while clk low,
   // then confirm the T1 decode appears at once.
   task automatic clear_pulse(input string tag);
      @(negedge clk);
      #2 clear_bar = 1'b0;
      #1 check({tag, "_held"}, obs(), reset_vec());
      repeat (2) @(negedge clk);
      #2 clear_bar = 1'b1;
      #1 check({tag, "_rel_t1"}, obs(), exp_vec(4'h0, 0));
   endtask

   // Execute one instruction; abort_step >= 0 asserts clear_bar mid-way.
   task automatic run_instr(input logic [3:0] op, input int abort_step);
      int len;
      len = instr_len(op);
      for (int s = 0; s < len; s++) exp_q.push_back(exp_vec(op, s));
      for (int s = 0; s < len; s++) begin
         @(posedge clk);
         #1;
         if (s == 0) opcode = 4'($urandom_range(0, 15));  // stale IR, ignored
         if (s == 2) opcode = op;                         // IR loads in T3
         check($sformatf("op%h_T%0d", op, s + 1), obs(), exp_q.pop_front());
         if (s == abort_step) begin
            #1 clear_bar = 1'b0;
            #1 check($sformatf("op%h_midrst_T%0d", op, s + 1), obs(), reset_vec());
            repeat (2) @(negedge clk);
            #2 clear_bar = 1'b1;
            #1 check("midrst_rel_t1", obs(), exp_vec(4'h0, 0));
            exp_q.delete();
            return;
         end
      end
      if (op == 4'hF) begin
         for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 check($sformatf("halt_c%0d", c), obs(), halt_vec());
         end
         clear_pulse("halt_clr");
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] op;
      int abort;
      clear_bar = 1'b0;
      opcode    = 4'h0;

      repeat (5) @(posedge clk);
      #1 check("reset", obs(), reset_vec());
      @(negedge clk);
      #2 clear_bar = 1'b1;
      #1 check("release_t1", obs(), exp_vec(4'h0, 0));

      // Directed: every opcode class, mid-instruction reset, halt.
      run_instr(4'h0, -1);
      run_instr(4'h1, -1);
      run_instr(4'h2, -1);
      run_instr(4'hE, -1);
      run_instr(4'h7, -1);
      run_instr(4'h1, 4);   // clear during ADD T5
      run_instr(4'h0, -1);
      run_instr(4'hF, -1);
      run_instr(4'h2, -1);

      // Random program.
      for (int i = 0; i < 60; i++) begin
         op = 4'($urandom_range(0, 15));
         abort = -1;
         if (op != 4'hF && $urandom_range(0, 9) == 0)
            abort = $urandom_range(0, instr_len(op) - 1);
         run_instr(op, abort);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
